// File: rtl/tracker_pkg.sv
// tracker_pkg: direction codes, FSM state encodings and shortest-path helpers
// shared by the tracker motion sequencer.
package tracker_pkg;
  localparam int ANG_MAX_DEF = 360;
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;
  localparam logic [1:0] DIR_CW   = 2'b10;
  typedef logic [3:0] state_t;
  localparam state_t IDLE     = 4'd0;
  localparam state_t MV_TETA  = 4'd1;
  localparam state_t SET_TETA = 4'd2;
  localparam state_t MV_FI    = 4'd3;
  localparam state_t SET_FI   = 4'd4;
  localparam state_t AU_TETA  = 4'd5;
  localparam state_t AU_SET_T = 4'd6;
  localparam state_t AU_FI    = 4'd7;
  localparam state_t AU_SET_F = 4'd8;
  // Both angles are already in 0..amax-1, so one conditional add replaces a modulo.
  function automatic logic [1:0] path_dir(input int pos, input int tgt, input int amax);
    int diff;
    diff = tgt >= pos ? tgt - pos : tgt - pos + amax;
    return diff == 0 ? DIR_HOLD : diff <= amax / 2 ? DIR_CW : DIR_CCW;
  endfunction
  function automatic int wrap_inc(input int pos, input int amax);
    return pos == amax - 1 ? 0 : pos + 1;
  endfunction
  function automatic int wrap_dec(input int pos, input int amax);
    return pos == 0 ? amax - 1 : pos - 1;
  endfunction
endpackage

// File: rtl/tracker_motion_sequencer_step_tick_gen.sv
// step_tick_gen: step-rate prescaler; ticks once every STEP_DIV enabled cycles,
// held at zero while disabled or cleared.
module step_tick_gen #(
  parameter int STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(STEP_DIV);
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(STEP_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/tracker_motion_sequencer.sv
// tracker_motion_sequencer: manual/automatic two-axis stepper sequencer with open-loop positions.
// Define ABORT_EN to add an abort input that cancels any move in progress.
module tracker_motion_sequencer
  import tracker_pkg::*;
#(
  parameter int ANG_W          = 9,
  parameter int ANG_MAX        = ANG_MAX_DEF,
  parameter int STEP_DIV       = 1000,
  parameter int SETTLE_CYC     = 5000,
  parameter int AUTO_MAX_STEPS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_auto,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ANG_W-1:0] teta_d,
  input  logic [ANG_W-1:0] fi_d,
  input  logic [1:0]       auto_teta_dir,
  input  logic [1:0]       auto_fi_dir,
`ifdef ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       S_out_teta,
  output logic [1:0]       S_out_fi,
  output logic             step_teta,
  output logic             step_fi,
  output logic [ANG_W-1:0] teta_pos,
  output logic [ANG_W-1:0] fi_pos,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int AW = $clog2(AUTO_MAX_STEPS + 1);
  state_t state, nxt;
  logic run, tick, ab, accept, bad, set_end, au_cap, mv, au_t_ok, au_f_ok;
  logic [ANG_W-1:0] tgt_teta, tgt_fi;
  logic [SW-1:0] set_cnt;
  logic [AW-1:0] au_cnt;
  logic [1:0] d_teta, d_fi;
`ifdef ABORT_EN
  assign ab = abort && state != IDLE;
`else
  assign ab = 1'b0;
`endif
  assign d_teta = path_dir(int'(teta_pos), int'(tgt_teta), ANG_MAX);
  assign d_fi = path_dir(int'(fi_pos), int'(tgt_fi), ANG_MAX);
  assign au_t_ok = auto_teta_dir == DIR_CCW || auto_teta_dir == DIR_CW;
  assign au_f_ok = auto_fi_dir == DIR_CCW || auto_fi_dir == DIR_CW;
  assign S_out_teta = state == MV_TETA ? d_teta : state == AU_TETA && au_t_ok ? auto_teta_dir : DIR_HOLD;
  assign S_out_fi = state == MV_FI ? d_fi : state == AU_FI && au_f_ok ? auto_fi_dir : DIR_HOLD;
  // Only the active move state can drive a non-hold direction, so this also keeps the axes exclusive.
  assign step_teta = tick && !ab && S_out_teta != DIR_HOLD;
  assign step_fi = tick && !ab && S_out_fi != DIR_HOLD;
  assign mv = state inside {MV_TETA, MV_FI, AU_TETA, AU_FI};
  assign busy = state != IDLE;
  assign cmd_ready = run && state == IDLE && !mode_auto;
  assign accept = cmd_valid && cmd_ready;
  assign bad = int'(teta_d) >= ANG_MAX || int'(fi_d) >= ANG_MAX;
  assign set_end = set_cnt == SW'(SETTLE_CYC - 1);
  assign au_cap = au_cnt == AW'(AUTO_MAX_STEPS - 1);
  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != nxt),
    .en   (mv),
    .tick (tick)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = mode_auto ? AU_TETA : accept && !bad ? MV_TETA : IDLE;
      MV_TETA:  nxt = d_teta == DIR_HOLD ? SET_TETA : MV_TETA;
      SET_TETA: nxt = set_end ? MV_FI : SET_TETA;
      MV_FI:    nxt = d_fi == DIR_HOLD ? SET_FI : MV_FI;
      SET_FI:   nxt = set_end ? IDLE : SET_FI;
      AU_TETA:  nxt = tick && (!au_t_ok || au_cap) ? AU_SET_T : AU_TETA;
      AU_SET_T: nxt = set_end ? (mode_auto ? AU_FI : IDLE) : AU_SET_T;
      AU_FI:    nxt = tick && (!au_f_ok || au_cap) ? AU_SET_F : AU_FI;
      AU_SET_F: nxt = set_end ? (mode_auto ? AU_TETA : IDLE) : AU_SET_F;
      default:  nxt = IDLE;
    endcase
    if (ab) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
      tgt_teta <= '0;
      tgt_fi <= '0;
      teta_pos <= '0;
      fi_pos <= '0;
      set_cnt <= '0;
      au_cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      run <= 1'b1;
      if (accept && !bad) begin
        tgt_teta <= teta_d;
        tgt_fi <= fi_d;
      end
      if (step_teta)
        teta_pos <= S_out_teta == DIR_CW ? ANG_W'(wrap_inc(int'(teta_pos), ANG_MAX)) : ANG_W'(wrap_dec(int'(teta_pos), ANG_MAX));
      if (step_fi)
        fi_pos <= S_out_fi == DIR_CW ? ANG_W'(wrap_inc(int'(fi_pos), ANG_MAX)) : ANG_W'(wrap_dec(int'(fi_pos), ANG_MAX));
      set_cnt <= state != nxt ? '0 : set_cnt + 1'b1;
      au_cnt <= state != nxt ? '0 : au_cnt + AW'(step_teta || step_fi);
      done <= state == SET_FI && set_end && !ab;
      err <= (accept && bad) || ab;
    end
endmodule

// File: tb/tb_tracker_motion_sequencer.sv
// tb_tracker_motion_sequencer: directed scoreboard bench for tracker_motion_sequencer;
// expected step events are queued per command and matched as the DUT steps.
module tb_tracker_motion_sequencer;
  import tracker_pkg::*;
  localparam int W = 9, AM = 360;
  typedef struct packed {
    logic       ax;
    logic [1:0] dir;
    logic [W-1:0] pos;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, mode_auto = 1'b0, cmd_valid = 1'b0;
  logic [W-1:0] teta_d = '0, fi_d = '0;
  logic [1:0] auto_teta_dir = '0, auto_fi_dir = '0;
  logic cmd_ready, step_teta, step_fi, busy, done, err;
  logic [1:0] S_out_teta, S_out_fi;
  logic [W-1:0] teta_pos, fi_pos;
`ifdef ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0, failures = 0;
  int t_steps = 0, f_steps = 0, done_cnt = 0, err_cnt = 0, cyc = 0, last_t = 0, tf_gap = 0;
  logic last_ax = 1'b0;
  ev_t q[$];

  always #5 clk = ~clk;

  tracker_motion_sequencer #(
    .ANG_W(W), .ANG_MAX(AM), .STEP_DIV(4), .SETTLE_CYC(8), .AUTO_MAX_STEPS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_auto(mode_auto), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .teta_d(teta_d), .fi_d(fi_d), .auto_teta_dir(auto_teta_dir), .auto_fi_dir(auto_fi_dir),
`ifdef ABORT_EN
    .abort(abort),
`endif
    .S_out_teta(S_out_teta), .S_out_fi(S_out_fi), .step_teta(step_teta), .step_fi(step_fi),
    .teta_pos(teta_pos), .fi_pos(fi_pos), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock of observation: every step pulse is matched against the head of the scoreboard.
  task automatic mon();
    ev_t g, e;
    @(negedge clk);
    cyc++;
    if (step_teta || step_fi) begin
      g = {step_fi, step_fi ? S_out_fi : S_out_teta, step_fi ? fi_pos : teta_pos};
      checks++;
      assert (q.size() != 0 && !(step_teta && step_fi)) else begin
        failures++;
        $error("FAIL step_unexpected observed ax=%0d dir=%b pos=%0d both=%0d expected no step", g.ax, g.dir, g.pos, step_teta && step_fi);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (g === e) else begin
          failures++;
          $error("FAIL step_event observed ax=%0d dir=%b pos=%0d expected ax=%0d dir=%b pos=%0d", g.ax, g.dir, g.pos, e.ax, e.dir, e.pos);
        end
      end
      if (step_fi) begin
        f_steps++;
        if (!last_ax) tf_gap = cyc - last_t;
      end else begin
        t_steps++;
        last_t = cyc;
      end
      last_ax = step_fi;
    end
    done_cnt += int'(done);
    err_cnt += int'(err);
  endtask

  // Shortest-path model: direction is fixed for the whole move, ties at AM/2 go CW.
  task automatic expect_move(input logic ax, input int from, input int to);
    int diff, n, p;
    logic cw;
    ev_t e;
    diff = ((to - from) % AM + AM) % AM;
    cw = diff <= AM / 2;
    n = cw ? diff : AM - diff;
    p = from;
    for (int i = 0; i < n; i++) begin
      e = {ax, cw ? DIR_CW : DIR_CCW, W'(p)};
      q.push_back(e);
      p = cw ? (p + 1) % AM : (p + AM - 1) % AM;
    end
  endtask

  task automatic push_ev(input logic ax, input logic [1:0] dir, input int p);
    ev_t e;
    e = {ax, dir, W'(p)};
    q.push_back(e);
  endtask

  task automatic cmd(input int t, input int f);
    teta_d = W'(t);
    fi_d = W'(f);
    cmd_valid = 1'b1;
    mon();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      mon();
      i++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int bd, be, bt, bf, i;
    #12;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pos", int'(teta_pos), 0);
    mon();
    rst_n = 1'b1;
    mon();
    chk("ready_after_rel", int'(cmd_ready), 1);

    // manual 0/0 -> 10/350
    bd = done_cnt;
    expect_move(1'b0, 0, 10);
    expect_move(1'b1, 0, 350);
    cmd(10, 350);
    chk("man_busy", int'(busy), 1);
    wait_idle("man1", 400);
    chk("man1_teta", int'(teta_pos), 10);
    chk("man1_fi", int'(fi_pos), 350);
    chk("man1_done", done_cnt - bd, 1);
    chk("man1_gap", tf_gap, 13);
    chk("man1_queue", q.size(), 0);
    chk("man1_dirs", int'({S_out_teta, S_out_fi}), 0);

    // wrap through 359->0 and the 180 tie
    expect_move(1'b0, 10, 350);
    cmd(350, 350);
    wait_idle("wrap_a", 400);
    expect_move(1'b0, 350, 5);
    cmd(5, 350);
    wait_idle("wrap_b", 400);
    chk("wrap_teta", int'(teta_pos), 5);
    expect_move(1'b0, 5, 0);
    cmd(0, 350);
    wait_idle("wrap_c", 400);
    expect_move(1'b0, 0, 180);
    cmd(180, 350);
    wait_idle("tie", 1500);
    chk("tie_teta", int'(teta_pos), 180);
    chk("tie_queue", q.size(), 0);

    // out-of-range targets
    be = err_cnt;
    bd = done_cnt;
    cmd(360, 0);
    mon();
    mon();
    chk("bad_err", err_cnt - be, 1);
    chk("bad_busy", int'(busy), 0);
    chk("bad_ready", int'(cmd_ready), 1);
    chk("bad_teta", int'(teta_pos), 180);
    cmd(0, 400);
    mon();
    mon();
    chk("bad_fi_err", err_cnt - be, 2);
    chk("bad_done", done_cnt - bd, 0);

    // reset in the middle of a teta move
    expect_move(1'b0, 180, 100);
    cmd(100, 350);
    repeat (10) mon();
    chk("mid_dir", int'(S_out_teta), int'(DIR_CCW));
    chk("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_teta", int'(teta_pos), 0);
    chk("async_fi", int'(fi_pos), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_dir", int'({S_out_teta, S_out_fi}), 0);
    chk("async_step", int'({step_teta, step_fi}), 0);
    chk("async_ready", int'(cmd_ready), 0);
    q.delete();
    mon();
    mon();
    rst_n = 1'b1;
    mon();
    chk("rerel_ready", int'(cmd_ready), 1);

    // automatic passes: teta CCW x5, fi CW capped at 8, then teta CW capped at 8
    for (int k = 0; k < 5; k++) push_ev(1'b0, DIR_CCW, (AM - k) % AM);
    for (int k = 0; k < 8; k++) push_ev(1'b1, DIR_CW, k);
    for (int k = 0; k < 8; k++) push_ev(1'b0, DIR_CW, (355 + k) % AM);
    bd = done_cnt;
    bt = t_steps;
    bf = f_steps;
    mode_auto = 1'b1;
    auto_teta_dir = DIR_CCW;
    auto_fi_dir = DIR_CW;
    mon();
    chk("auto_busy", int'(busy), 1);
    chk("auto_ready", int'(cmd_ready), 0);
    i = 0;
    while (t_steps - bt < 5 && i < 200) begin mon(); i++; end
    chk("auto_t5", t_steps - bt, 5);
    mon();
    auto_teta_dir = DIR_HOLD;
    i = 0;
    while (f_steps - bf < 8 && i < 300) begin mon(); i++; end
    chk("auto_f8", f_steps - bf, 8);
    mon();
    chk("auto_teta355", int'(teta_pos), 355);
    chk("auto_fi8", int'(fi_pos), 8);
    auto_teta_dir = DIR_CW;
    i = 0;
    while (t_steps - bt < 13 && i < 300) begin mon(); i++; end
    chk("auto_t13", t_steps - bt, 13);
    mon();
    mode_auto = 1'b0;
    auto_teta_dir = DIR_HOLD;
    auto_fi_dir = DIR_HOLD;
    wait_idle("auto_exit", 100);
    chk("auto_teta_end", int'(teta_pos), 3);
    chk("auto_fi_end", int'(fi_pos), 8);
    chk("auto_no_done", done_cnt - bd, 0);
    chk("auto_queue", q.size(), 0);

`ifdef ABORT_EN
    expect_move(1'b0, 3, 10);
    push_ev(1'b1, DIR_CW, 8);
    push_ev(1'b1, DIR_CW, 9);
    bd = done_cnt;
    be = err_cnt;
    bf = f_steps;
    cmd(10, 20);
    i = 0;
    while (f_steps - bf < 2 && i < 300) begin mon(); i++; end
    chk("ab_f2", f_steps - bf, 2);
    mon();
    abort = 1'b1;
    mon();
    abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_dir", int'(S_out_fi), 0);
    chk("ab_err", int'(err), 1);
    repeat (20) mon();
    chk("ab_err_cnt", err_cnt - be, 1);
    chk("ab_no_done", done_cnt - bd, 0);
    chk("ab_teta", int'(teta_pos), 10);
    chk("ab_fi", int'(fi_pos), 10);
    chk("ab_queue", q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
